mult32x32_req_if: RTL

// - Request/response shell around the 32x32 sequential multiplier core (FSM + datapath).
// - Accepts operand pairs on a valid/ready port and drives the core's a/b/start.
// - Tracks the core's busy, captures the 64-bit product and presents it on a valid/ready result port.
// - Sits directly upstream (start, a, b) and downstream (product) of the core.

---
 rtl/mult32x32_pkg.sv | 14 +
 rtl/mult32x32_req_if_if.sv | 35 +++
 rtl/mult32x32_req_if.sv | 99 +++++++++
 3 files changed

// File: rtl/mult32x32_pkg.sv
// Shared types and widths for the 32x32 multiplier request/response shell.
package mult32x32_pkg;

   localparam int unsigned OP_W   = 32;
   localparam int unsigned PROD_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      RUN
   } req_st_t;

endpackage

// File: rtl/mult32x32_req_if_if.sv
// Request, core-control and result signals of the multiplier shell.
// slave: the shell's view; master: the environment (requester, core, consumer).
interface mult32x32_req_if_if #(
   parameter int unsigned CNT_W = 16
);
   import mult32x32_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_a;
   logic [OP_W-1:0]   in_b;
   logic              mul_start;
   logic [OP_W-1:0]   mul_a;
   logic [OP_W-1:0]   mul_b;
   logic              mul_busy;
   logic [PROD_W-1:0] mul_product;
   logic              res_valid;
   logic              res_ready;
   logic [PROD_W-1:0] res_data;
   logic              timeout_err;
   logic [CNT_W-1:0]  res_count;

   modport slave (
      input  in_valid, in_a, in_b, mul_busy, mul_product, res_ready,
      output in_ready, mul_start, mul_a, mul_b, res_valid, res_data,
             timeout_err, res_count
   );

   modport master (
      output in_valid, in_a, in_b, mul_busy, mul_product, res_ready,
      input  in_ready, mul_start, mul_a, mul_b, res_valid, res_data,
             timeout_err, res_count
   );

endinterface

// File: rtl/mult32x32_req_if.sv
// Request/response shell around the 32x32 sequential multiplier core.
// Latches an operand pair, pulses start, follows the core's busy and
// presents the captured product on a valid/ready result port.
module mult32x32_req_if #(
   parameter int unsigned TIMEOUT = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   mult32x32_req_if_if.slave bus
);
   import mult32x32_pkg::*;

   localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   req_st_t           state;
   logic              start_q;
   logic [OP_W-1:0]   a_q;
   logic [OP_W-1:0]   b_q;
   logic              res_valid_q;
   logic [PROD_W-1:0] res_data_q;
   logic              tmo_q;
   logic [TMR_W-1:0]  timer;
   logic [TMR_W-1:0]  timer_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_w;

   assign in_ready_w = (state == IDLE) && !res_valid_q;
   assign timer_nxt  = timer + TMR_W'(1);

   assign bus.in_ready    = in_ready_w;
   assign bus.mul_start   = start_q;
   assign bus.mul_a       = a_q;
   assign bus.mul_b       = b_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.timeout_err = tmo_q;
   assign bus.res_count   = cnt_q;

   // Control FSM with registered start/error pulses, operand and result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         start_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         tmo_q       <= 1'b0;
         timer       <= '0;
         cnt_q       <= '0;
      end else begin
         start_q <= 1'b0;
         tmo_q   <= 1'b0;

         if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
         end

         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_w) begin
                  a_q     <= bus.in_a;
                  b_q     <= bus.in_b;
                  start_q <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.mul_busy) begin
                  state <= RUN;
               end else if (timer_nxt == TMR_LAST) begin
                  // abort decided on the incremented count so the pulse lands
                  // TIMEOUT cycles after ISSUE
                  tmo_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  timer <= timer_nxt;
               end
            end
            RUN: begin
               if (!bus.mul_busy) begin
                  res_data_q  <= bus.mul_product;
                  res_valid_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
